fifo_write_arbiter: RTL and testbench

- Shares one 16x9 first-word-fall-through block-RAM FIFO between several producers; owns the FIFO's write port.
- Granting is round-robin and packet-atomic: a producer keeps the grant until it writes an end-of-packet word (bit 8 set) or hits the burst limit.
- Sits between the I/O capture units and the FIFO; the FIFO's read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_write_arbiter_if.sv | 36 +++
 rtl/rr_priority_pick.sv | 46 ++++
 rtl/fifo_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write arbiter: FSM state encoding,
//   default sizing constants and the end-of-packet bit locator.
//   No ports; imported by the interface, the picker and the top.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 9;
  localparam int DEF_MAX_BURST = 16;

  // The top bit of every FIFO word marks end-of-packet.
  function automatic int eop_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if
//   Bundles the producer-side handshake and the FIFO write port handled by
//   the arbiter.
//   Producer side : req, req_data (slice i = bits [i*WIDTH +: WIDTH]), req_ack
//   Status        : grant (one-hot owner), burst_done (release pulse)
//   FIFO side     : fifo_din, fifo_wr_en, fifo_full, fifo_prog_full
//   modport master : the arbiter (drives acks, grant and the FIFO write port)
//   modport slave  : the environment (producers plus the FIFO)
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) ();

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ack;
  logic [NUM_REQ-1:0]       grant;
  logic [WIDTH-1:0]         fifo_din;
  logic                     fifo_wr_en;
  logic                     fifo_full;
  logic                     fifo_prog_full;
  logic                     burst_done;

  modport master (
    input  req, req_data, fifo_full, fifo_prog_full,
    output req_ack, grant, fifo_din, fifo_wr_en, burst_done
  );

  modport slave (
    output req, req_data, fifo_full, fifo_prog_full,
    input  req_ack, grant, fifo_din, fifo_wr_en, burst_done
  );

endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin picker. Returns the first set request at or
//   after rr_ptr, wrapping around.
//   Ports:
//     req    in  NUM_REQ  request vector
//     rr_ptr in  PTR_W    highest-priority index
//     winner out NUM_REQ  one-hot winner (zero when no request)
//     valid  out 1        at least one request present
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  // Two copies of the request vector side by side: masking off everything
  // below rr_ptr and taking the lowest remaining bit gives the wrapped
  // round-robin choice with a plain priority encoder.
  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] masked;
  int                   pick;

  assign dbl = {req, req};

  always_comb begin
    masked = '0;
    pick   = 0;
    winner = '0;
    valid  = |req;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      masked[i] = dbl[i] & (i >= int'(rr_ptr));
    end
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (masked[i]) pick = i;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (valid && ((pick % NUM_REQ) == j)) winner[j] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Owns the write port of a shared FWFT FIFO and hands it to one producer
//   at a time, round-robin, for a whole packet (until an EOP word is written)
//   or until MAX_BURST words have been written.
//   Ports:
//     clk    in  single clock, rising edge
//     srst_n in  synchronous reset, active-low
//     bus    fifo_write_arbiter_if.master:
//       req/req_data in, req_ack out (combinational, owner only)
//       grant out (registered one-hot), burst_done out (registered pulse)
//       fifo_din/fifo_wr_en out, fifo_full/fifo_prog_full in
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                 clk,
  input  logic                 srst_n,
  fifo_write_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST);
  localparam int EOP   = eop_bit(WIDTH);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               burst_done_q, burst_done_d;

  logic [NUM_REQ-1:0] pick_winner;
  logic               pick_valid;
  logic               owner_req;
  logic [WIDTH-1:0]   owner_data;
  logic               wr_fire;
  logic               last_word;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] cur);
    return (cur == PTR_W'(NUM_REQ-1)) ? '0 : cur + 1'b1;
  endfunction

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Owner's word and the write decision for this cycle
  assign owner_req  = bus.req[owner_q];
  assign owner_data = bus.req_data[int'(owner_q)*WIDTH +: WIDTH];
  // fifo_full gates the write directly, so the FIFO can never overflow;
  // an EOP word blocked by fifo_full simply retries next cycle.
  assign wr_fire    = (state_q == BURST) && owner_req && !bus.fifo_full;
  assign last_word  = owner_data[EOP] || (word_cnt_q == CNT_W'(MAX_BURST-1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    word_cnt_d   = word_cnt_q;
    burst_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // prog_full only throttles the start of a new packet.
        if (pick_valid && !bus.fifo_prog_full) begin
          grant_d    = pick_winner;
          owner_d    = onehot_to_idx(pick_winner);
          word_cnt_d = '0;
          state_d    = BURST;
        end else begin
          grant_d = '0;
        end
      end
      BURST: begin
        // No timeout: a silent owner keeps the grant.
        if (wr_fire) begin
          if (last_word) begin
            grant_d      = '0;
            rr_ptr_d     = next_ptr(owner_q);
            burst_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered control state
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      word_cnt_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      word_cnt_q   <= word_cnt_d;
      burst_done_q <= burst_done_d;
    end
  end

  // Output muxing: data and ack are zero unless a write happens
  always_comb begin
    bus.req_ack    = '0;
    bus.fifo_wr_en = wr_fire;
    bus.fifo_din   = '0;
    if (wr_fire) begin
      bus.req_ack  = grant_q;
      bus.fifo_din = owner_data;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.burst_done = burst_done_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
//   Self-checking bench for fifo_write_arbiter. Producers are modelled as
//   per-requester word queues; the expected FIFO write order is queued in a
//   scoreboard as stimulus is set up and checked on every write.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int W  = 9;
  localparam int MB = 16;

  typedef struct {
    int           idx;
    logic [W-1:0] word;
  } sb_t;

  logic clk = 1'b0;
  logic srst_n;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ   (NR),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  int           errors   = 0;
  int           checks   = 0;
  int           wr_total = 0;
  logic [NR-1:0] ack_prev;
  logic         full_next, pfull_next, rst_next;
  logic [W-1:0] prod_q[NR][$];
  sb_t          sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_word(input int r, input logic [W-1:0] w);
    prod_q[r].push_back(w);
  endtask

  task automatic expect_word(input int r, input logic [W-1:0] w);
    sb_t e;
    e.idx  = r;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic monitor();
    sb_t e;
    if (bus.fifo_wr_en === 1'b1) begin
      wr_total++;
      check_eq("wr_while_full", 32'(bus.fifo_full), 32'd0);
      if (sb.size() == 0) begin
        check_eq("extra_write", 32'(bus.fifo_wr_en), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("wr_ack", 32'(bus.req_ack), 32'd1 << e.idx);
        check_eq("wr_din", 32'(bus.fifo_din), 32'(e.word));
      end
    end else begin
      check_eq("idle_din", 32'(bus.fifo_din), 32'd0);
      check_eq("idle_ack", 32'(bus.req_ack), 32'd0);
    end
    ack_prev = bus.req_ack;
  endtask

  // One clock: retire acked words, drive inputs, check at the falling edge.
  task automatic cycle();
    logic [NR-1:0]   req_v;
    logic [NR*W-1:0] data_v;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (ack_prev[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
    end
    ack_prev = '0;
    data_v   = '0;
    for (int i = 0; i < NR; i++) begin
      req_v[i] = (prod_q[i].size() > 0);
      if (prod_q[i].size() > 0) data_v[i*W +: W] = prod_q[i][0];
    end
    bus.req            = req_v;
    bus.req_data       = data_v;
    bus.fifo_full      = full_next;
    bus.fifo_prog_full = pfull_next;
    srst_n             = rst_next;
    @(negedge clk);
    monitor();
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NR; i++) prod_q[i].delete();
    sb.delete();
    ack_prev = '0;
  endtask

  task automatic do_reset();
    clear_stim();
    rst_next = 1'b0;
    cycle();
    cycle();
    rst_next = 1'b1;
    clear_stim();
  endtask

  task automatic wait_writes(input int target, input int bound, input string tag);
    int n = 0;
    while (wr_total < target && n < bound) begin
      cycle();
      n++;
    end
    check_eq(tag, 32'(wr_total), 32'(target));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g1[6]  = '{0, 1, 1, 1, 0, 0};
    int d1[6]  = '{0, 0, 0, 0, 1, 0};
    int w1[6]  = '{0, 1, 1, 1, 0, 0};
    int g2[11] = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1, 0};
    int d2[11] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    srst_n = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_prog_full = 1'b0;
    rst_next = 1'b0;
    full_next = 1'b0;
    pfull_next = 1'b0;
    ack_prev = '0;

    // Reset values
    repeat (3) cycle();
    check_eq("rst_grant", 32'(bus.grant), 32'd0);
    check_eq("rst_done", 32'(bus.burst_done), 32'd0);
    check_eq("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check_eq("rst_din", 32'(bus.fifo_din), 32'd0);
    check_eq("rst_ack", 32'(bus.req_ack), 32'd0);
    rst_next = 1'b1;
    cycle();

    // Single packet from requester 0
    add_word(0, 9'h011); add_word(0, 9'h022); add_word(0, 9'h133);
    expect_word(0, 9'h011); expect_word(0, 9'h022); expect_word(0, 9'h133);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_eq($sformatf("t1_grant%0d", k), 32'(bus.grant), 32'(g1[k]));
      check_eq($sformatf("t1_done%0d", k), 32'(bus.burst_done), 32'(d1[k]));
      check_eq($sformatf("t1_wr%0d", k), 32'(bus.fifo_wr_en), 32'(w1[k]));
    end
    check_eq("t1_drain", 32'(sb.size()), 32'd0);

    // Round-robin over four requesters, one-word packets
    do_reset();
    add_word(0, 9'h10A); add_word(0, 9'h10E);
    add_word(1, 9'h10B); add_word(2, 9'h10C); add_word(3, 9'h10D);
    expect_word(0, 9'h10A); expect_word(1, 9'h10B); expect_word(2, 9'h10C);
    expect_word(3, 9'h10D); expect_word(0, 9'h10E);
    for (int k = 0; k < 11; k++) begin
      cycle();
      check_eq($sformatf("t2_grant%0d", k), 32'(bus.grant), 32'(g2[k]));
      check_eq($sformatf("t2_done%0d", k), 32'(bus.burst_done), 32'(d2[k]));
    end
    check_eq("t2_drain", 32'(sb.size()), 32'd0);

    // Burst limit: requester 2 sends 20 non-EOP words, requester 3 one packet
    for (int i = 0; i < 20; i++) add_word(2, 9'(i + 1));
    add_word(3, 9'h1AA);
    for (int i = 0; i < 16; i++) expect_word(2, 9'(i + 1));
    expect_word(3, 9'h1AA);
    for (int i = 16; i < 20; i++) expect_word(2, 9'(i + 1));
    wait_writes(wr_total + 21, 200, "t3_writes");
    // Producer went silent mid-packet: grant is held with no timeout.
    repeat (5) begin
      cycle();
      check_eq("t3_hold_grant", 32'(bus.grant), 32'h4);
      check_eq("t3_hold_wr", 32'(bus.fifo_wr_en), 32'd0);
    end

    // Backpressure mid-burst, then EOP presented while full
    do_reset();
    add_word(1, 9'h041); add_word(1, 9'h042); add_word(1, 9'h043);
    add_word(1, 9'h044); add_word(1, 9'h045); add_word(1, 9'h146);
    expect_word(1, 9'h041); expect_word(1, 9'h042); expect_word(1, 9'h043);
    expect_word(1, 9'h044); expect_word(1, 9'h045); expect_word(1, 9'h146);
    base = wr_total;
    wait_writes(base + 2, 20, "t4_pre");
    full_next = 1'b1;
    repeat (3) begin
      cycle();
      check_eq("t4_full_wr", 32'(bus.fifo_wr_en), 32'd0);
      check_eq("t4_full_grant", 32'(bus.grant), 32'h2);
    end
    full_next = 1'b0;
    wait_writes(base + 5, 20, "t4_mid");
    full_next = 1'b1;
    cycle();
    check_eq("t4_eop_full_wr", 32'(bus.fifo_wr_en), 32'd0);
    full_next = 1'b0;
    cycle();
    check_eq("t4_eop_retry_grant", 32'(bus.grant), 32'h2);
    check_eq("t4_eop_retry_wr", 32'(bus.fifo_wr_en), 32'd1);
    cycle();
    check_eq("t4_release_grant", 32'(bus.grant), 32'd0);
    check_eq("t4_release_done", 32'(bus.burst_done), 32'd1);
    check_eq("t4_drain", 32'(sb.size()), 32'd0);

    // prog_full blocks new grants while idle
    pfull_next = 1'b1;
    add_word(1, 9'h155);
    expect_word(1, 9'h155);
    repeat (4) begin
      cycle();
      check_eq("t5_blocked_grant", 32'(bus.grant), 32'd0);
    end
    pfull_next = 1'b0;
    cycle();
    check_eq("t5_arb_grant", 32'(bus.grant), 32'd0);
    cycle();
    check_eq("t5_grant", 32'(bus.grant), 32'h2);
    check_eq("t5_wr", 32'(bus.fifo_wr_en), 32'd1);
    cycle();
    check_eq("t5_done", 32'(bus.burst_done), 32'd1);
    check_eq("t5_drain", 32'(sb.size()), 32'd0);

    // Reset during word 5 of a packet from requester 2
    for (int i = 0; i < 9; i++) add_word(2, 9'(9'h081 + i));
    add_word(2, 9'h18A);
    for (int i = 0; i < 5; i++) expect_word(2, 9'(9'h081 + i));
    base = wr_total;
    wait_writes(base + 4, 30, "t6_pre");
    rst_next = 1'b0;
    cycle();
    check_eq("t6_word5", 32'(sb.size()), 32'd0);
    clear_stim();
    rst_next = 1'b1;
    cycle();
    check_eq("t6_grant", 32'(bus.grant), 32'd0);
    check_eq("t6_done", 32'(bus.burst_done), 32'd0);
    check_eq("t6_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check_eq("t6_din", 32'(bus.fifo_din), 32'd0);
    check_eq("t6_ack", 32'(bus.req_ack), 32'd0);
    // rr_ptr back at 0: requester 0 must win over requester 3.
    add_word(0, 9'h1C0); add_word(3, 9'h1C3);
    expect_word(0, 9'h1C0); expect_word(3, 9'h1C3);
    wait_writes(wr_total + 2, 20, "t6_post");
    cycle();
    check_eq("t6_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
